// File: rtl/mpmc10_pkg.sv
// Shared types and constants for the mpmc10 multi-port memory controller.
package mpmc10_pkg;

    localparam int unsigned MPMC10_URGENT_THRESH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        ISSUE = 2'd3
    } mpmc10_sched_state_t;

    // Command as stored in each per-port command FIFO.
    typedef struct packed {
        logic [7:0]   cid;
        logic [7:0]   tid;
        logic         cyc;
        logic         we;
        logic [31:0]  sel;
        logic [31:0]  adr;
        logic [255:0] dat;
    } wb_cmd_request256_t;

endpackage

// File: rtl/mpmc10_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module mpmc10_rr_pick #(
    parameter int unsigned NCHAN = 8,
    parameter int unsigned CHW   = $clog2(NCHAN)
) (
    input  logic [NCHAN-1:0] req,
    input  logic [CHW-1:0]   ptr,
    output logic             found,
    output logic [CHW-1:0]   idx
);

    localparam logic [CHW:0] NCHAN_W = (CHW+1)'(NCHAN);

    logic [CHW-1:0] cand [NCHAN];

    // cand[k] is the channel visited k steps after ptr, modulo NCHAN.
    for (genvar k = 0; k < NCHAN; k++) begin : g_cand
        logic [CHW:0] sum;
        assign sum     = {1'b0, ptr} + (CHW+1)'(k);
        assign cand[k] = (sum >= NCHAN_W) ? CHW'(sum - NCHAN_W) : CHW'(sum);
    end

    // Scan from the far end so the nearest candidate wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = int'(NCHAN) - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/mpmc10_chan_sched.sv
// Round-robin command scheduler with urgent override between per-port FIFOs
// and the memory-side state machine; one command in flight at a time.
module mpmc10_chan_sched
    import mpmc10_pkg::*;
#(
    parameter int unsigned NCHAN         = 8,
    parameter int unsigned CHW           = $clog2(NCHAN),
    parameter int unsigned URGENT_THRESH = MPMC10_URGENT_THRESH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCHAN-1:0]              chan_en,
    input  logic [NCHAN-1:0]              fifo_empty,
    input  logic [NCHAN-1:0]              fifo_v,
    input  logic [NCHAN-1:0]              fifo_rd_rst_busy,
    input  logic [NCHAN-1:0][4:0]         fifo_cnt,
    input  wb_cmd_request256_t [NCHAN-1:0] req_fifoo,
    output logic [NCHAN-1:0]              rd_fifo,
    output wb_cmd_request256_t            req_o,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [CHW-1:0]                req_chan,
    output logic                          req_urgent,
    output logic                          err_nov
);

    localparam logic [4:0]     THRESH = 5'(URGENT_THRESH);
    localparam logic [CHW-1:0] LAST   = CHW'(NCHAN - 1);

    mpmc10_sched_state_t state_q, state_d;
    logic [CHW-1:0]      sel_q, sel_d;
    logic                urg_q, urg_d;
    logic [CHW-1:0]      ptr_q, ptr_d;
    logic [NCHAN-1:0]    rd_fifo_d;
    wb_cmd_request256_t  req_o_d;
    logic                req_valid_d;
    logic [CHW-1:0]      req_chan_d;
    logic                req_urgent_d;
    logic                err_nov_d;

    logic [NCHAN-1:0]    eligible;
    logic [NCHAN-1:0]    urgent;
    logic [CHW-1:0]      sel_inc;
    logic [CHW-1:0]      pick_ptr;
    logic                urg_found, elig_found, pick_found;
    logic [CHW-1:0]      urg_idx, elig_idx, pick_idx;

    assign eligible = chan_en & ~fifo_empty & ~fifo_rd_rst_busy;

    always_comb begin
        urgent = '0;
        for (int i = 0; i < int'(NCHAN); i++) begin
            urgent[i] = eligible[i] & (fifo_cnt[i] >= THRESH);
        end
    end

    assign sel_inc = (sel_q == LAST) ? '0 : sel_q + CHW'(1);

    // On an ISSUE accept the pointer advances this cycle, so pick against the new value.
    assign pick_ptr = (state_q == ISSUE) ? sel_inc : ptr_q;

    mpmc10_rr_pick #(.NCHAN(NCHAN), .CHW(CHW)) u_pick_urgent (
        .req   (urgent),
        .ptr   (pick_ptr),
        .found (urg_found),
        .idx   (urg_idx)
    );

    mpmc10_rr_pick #(.NCHAN(NCHAN), .CHW(CHW)) u_pick_elig (
        .req   (eligible),
        .ptr   (pick_ptr),
        .found (elig_found),
        .idx   (elig_idx)
    );

    assign pick_found = urg_found | elig_found;
    assign pick_idx   = urg_found ? urg_idx : elig_idx;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        urg_d        = urg_q;
        ptr_d        = ptr_q;
        rd_fifo_d    = '0;
        req_o_d      = req_o;
        req_valid_d  = req_valid;
        req_chan_d   = req_chan;
        req_urgent_d = req_urgent;
        err_nov_d    = err_nov;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d     = pick_idx;
                    urg_d     = urg_found;
                    rd_fifo_d = NCHAN'(1) << pick_idx;
                    state_d   = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                if (fifo_v[sel_q]) begin
                    req_o_d      = req_fifoo[sel_q];
                    req_chan_d   = sel_q;
                    req_urgent_d = urg_q;
                    req_valid_d  = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    err_nov_d = 1'b1;
                    ptr_d     = sel_inc;
                    state_d   = IDLE;
                end
            end
            ISSUE: begin
                if (req_valid && req_ready) begin
                    req_valid_d = 1'b0;
                    ptr_d       = sel_inc;
                    if (pick_found) begin
                        sel_d     = pick_idx;
                        urg_d     = urg_found;
                        rd_fifo_d = NCHAN'(1) << pick_idx;
                        state_d   = READ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            urg_q      <= 1'b0;
            ptr_q      <= '0;
            rd_fifo    <= '0;
            req_o      <= '0;
            req_valid  <= 1'b0;
            req_chan   <= '0;
            req_urgent <= 1'b0;
            err_nov    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            urg_q      <= urg_d;
            ptr_q      <= ptr_d;
            rd_fifo    <= rd_fifo_d;
            req_o      <= req_o_d;
            req_valid  <= req_valid_d;
            req_chan   <= req_chan_d;
            req_urgent <= req_urgent_d;
            err_nov    <= err_nov_d;
        end
    end

endmodule

// File: tb/tb_mpmc10_chan_sched.sv
// Directed bench for mpmc10_chan_sched: FIFO models per channel, scoreboard of
// expected commands in issue order, protocol monitor on the falling edge.
module tb_mpmc10_chan_sched;
    import mpmc10_pkg::*;

    localparam int unsigned NCHAN = 8;
    localparam int unsigned CHW   = 3;

    typedef struct packed {
        logic [CHW-1:0]     ch;
        logic               urg;
        wb_cmd_request256_t d;
    } exp_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [NCHAN-1:0]              chan_en = '1;
    logic [NCHAN-1:0]              fifo_empty = '1;
    logic [NCHAN-1:0]              fifo_v = '0;
    logic [NCHAN-1:0]              fifo_rd_rst_busy = '0;
    logic [NCHAN-1:0][4:0]         fifo_cnt = '0;
    wb_cmd_request256_t [NCHAN-1:0] req_fifoo = '0;
    logic [NCHAN-1:0]              rd_fifo;
    wb_cmd_request256_t            req_o;
    logic                          req_valid;
    logic                          req_ready = 1'b0;
    logic [CHW-1:0]                req_chan;
    logic                          req_urgent;
    logic                          err_nov;

    logic [NCHAN-1:0]   sup_v = '0;
    wb_cmd_request256_t fq [NCHAN][$];
    exp_t               exp_q[$];
    int                 acc_t[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 cyc = 0;
    int                 acc_cnt = 0;
    int                 seq = 0;
    int                 rd_cnt [NCHAN];
    logic [NCHAN-1:0]   prev_fe = '1, prev_busy = '0, prev_en = '1, prev_rd = '0;

    mpmc10_chan_sched #(.NCHAN(NCHAN), .CHW(CHW), .URGENT_THRESH(24)) dut (
        .clk              (clk),
        .rst              (rst),
        .chan_en          (chan_en),
        .fifo_empty       (fifo_empty),
        .fifo_v           (fifo_v),
        .fifo_rd_rst_busy (fifo_rd_rst_busy),
        .fifo_cnt         (fifo_cnt),
        .req_fifoo        (req_fifoo),
        .rd_fifo          (rd_fifo),
        .req_o            (req_o),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_chan         (req_chan),
        .req_urgent       (req_urgent),
        .err_nov          (err_nov)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Standard-mode FIFO, read latency 1; status reflects the pop from the same edge.
    always @(posedge clk) begin
        for (int i = 0; i < int'(NCHAN); i++) begin
            if (rd_fifo[i] && fq[i].size() != 0) begin
                req_fifoo[i] <= fq[i].pop_front();
                fifo_v[i]    <= ~sup_v[i];
            end else begin
                fifo_v[i] <= 1'b0;
            end
            fifo_empty[i] <= (fq[i].size() == 0);
            fifo_cnt[i]   <= (fq[i].size() > 31) ? 5'd31 : 5'(fq[i].size());
        end
    end

    // Falling-edge monitor: read-enable legality and scoreboard on accept.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_fifo != '0) begin
                chk("rd_onehot", 512'($onehot(rd_fifo)), 512'(1));
                chk("rd_back_to_back", 512'(prev_rd), 512'(0));
                for (int i = 0; i < int'(NCHAN); i++) begin
                    if (rd_fifo[i]) begin
                        rd_cnt[i]++;
                        chk("rd_target_ok", 512'({prev_fe[i], prev_busy[i], ~prev_en[i]}), 512'(0));
                    end
                end
            end
            if (req_valid && req_ready) begin
                acc_cnt++;
                acc_t.push_back(cyc);
                chk("sb_has_entry", 512'(exp_q.size() != 0), 512'(1));
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_chan", 512'(req_chan), 512'(e.ch));
                    chk("sb_urgent", 512'(req_urgent), 512'(e.urg));
                    chk("sb_data", 512'(req_o), 512'(e.d));
                end
            end
        end
        prev_fe   = fifo_empty;
        prev_busy = fifo_rd_rst_busy;
        prev_en   = chan_en;
        prev_rd   = rd_fifo;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic urg, input bit expect_it,
                        output wb_cmd_request256_t d);
        exp_t e;
        d     = '0;
        d.cid = 8'(ch);
        d.tid = 8'(seq);
        d.cyc = 1'b1;
        d.we  = seq[0];
        d.sel = $urandom;
        d.adr = $urandom;
        d.dat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        seq++;
        fq[ch].push_back(d);
        if (expect_it) begin
            e.ch  = CHW'(ch);
            e.urg = urg;
            e.d   = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_entry(input int ch, input wb_cmd_request256_t d);
        exp_t e;
        e.ch  = CHW'(ch);
        e.urg = 1'b0;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || req_valid) && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 512'(exp_q.size()), 512'(0));
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n = 0;
        while (!req_valid && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, 512'(req_valid), 512'(1));
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        wb_cmd_request256_t d, d0;
        int n, base;
        for (int i = 0; i < int'(NCHAN); i++) rd_cnt[i] = 0;

        // Reset values
        tick();
        tick();
        chk("rst_rd_fifo", 512'(rd_fifo), 512'(0));
        chk("rst_req_valid", 512'(req_valid), 512'(0));
        chk("rst_req_o", 512'(req_o), 512'(0));
        chk("rst_req_chan", 512'(req_chan), 512'(0));
        chk("rst_req_urgent", 512'(req_urgent), 512'(0));
        chk("rst_err_nov", 512'(err_nov), 512'(0));
        rst = 1'b1;
        tick();

        // Single channel: exact pulse shape and latency
        req_ready = 1'b1;
        push(2, 1'b0, 1'b1, d0);
        n = 0;
        while (rd_fifo == '0 && n < 10) begin tick(); n++; end
        chk("single_rd", 512'(rd_fifo), 512'(8'h04));
        tick();
        chk("single_rd_low", 512'(rd_fifo), 512'(0));
        chk("single_not_valid_yet", 512'(req_valid), 512'(0));
        tick();
        chk("single_valid", 512'(req_valid), 512'(1));
        chk("single_chan", 512'(req_chan), 512'(2));
        chk("single_req_o", 512'(req_o), 512'(d0));
        tick();
        chk("single_idle_valid", 512'(req_valid), 512'(0));
        chk("single_idle_rd", 512'(rd_fifo), 512'(0));
        drain("single_drain", 20);

        // Round robin from pointer 0 at full rate
        reset_pulse();
        acc_t.delete();
        for (int r = 0; r < 2; r++) begin
            push(0, 1'b0, 1'b1, d);
            push(3, 1'b0, 1'b1, d);
            push(5, 1'b0, 1'b1, d);
        end
        drain("rr_drain", 60);
        chk("rr_accepts", 512'(acc_t.size()), 512'(6));
        if (acc_t.size() >= 6) chk("rr_throughput", 512'(acc_t[5] - acc_t[0]), 512'(15));
        chk("rr_no_empty_reads", 512'(rd_cnt[1] + rd_cnt[2] + rd_cnt[4] + rd_cnt[6] + rd_cnt[7]), 512'(1));

        // Urgent priority: ch6 reaches 24 entries, ch1 has 2
        reset_pulse();
        push(6, 1'b1, 1'b1, d);
        push(1, 1'b0, 1'b1, d);
        push(6, 1'b0, 1'b1, d);
        push(1, 1'b0, 1'b1, d);
        for (int k = 0; k < 22; k++) push(6, 1'b0, 1'b1, d);
        drain("urgent_drain", 200);

        // Backpressure on ch4
        req_ready = 1'b0;
        push(4, 1'b0, 1'b1, d0);
        push(4, 1'b0, 1'b1, d);
        wait_valid("bp_valid", 20);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_valid", 512'(req_valid), 512'(1));
            chk("bp_hold_chan", 512'(req_chan), 512'(4));
            chk("bp_hold_req_o", 512'(req_o), 512'(d0));
            chk("bp_hold_rd", 512'(rd_fifo), 512'(0));
        end
        base = acc_cnt;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        repeat (6) tick();
        chk("bp_one_accept", 512'(acc_cnt - base), 512'(1));
        req_ready = 1'b1;
        drain("bp_drain", 20);

        // Missing fifo_v after a read on ch7
        sup_v[7] = 1'b1;
        push(7, 1'b0, 1'b0, d);
        n = 0;
        while (!err_nov && n < 20) begin tick(); n++; end
        chk("err_nov_set", 512'(err_nov), 512'(1));
        sup_v[7] = 1'b0;
        push(0, 1'b0, 1'b1, d);
        push(7, 1'b0, 1'b1, d);
        drain("err_next_from_0", 30);

        // ch3 in rd_rst_busy and ch1 disabled are never read
        fifo_rd_rst_busy[3] = 1'b1;
        chan_en[1] = 1'b0;
        base = rd_cnt[3] + rd_cnt[1];
        push(3, 1'b0, 1'b0, d);
        push(3, 1'b0, 1'b0, d);
        push(1, 1'b0, 1'b0, d);
        push(2, 1'b0, 1'b1, d);
        drain("excl_drain", 30);
        repeat (8) tick();
        chk("excl_not_read", 512'(rd_cnt[3] + rd_cnt[1] - base), 512'(0));
        chk("err_nov_sticky", 512'(err_nov), 512'(1));
        expect_entry(3, fq[3][0]);
        expect_entry(1, fq[1][0]);
        expect_entry(3, fq[3][1]);
        fifo_rd_rst_busy[3] = 1'b0;
        chan_en[1] = 1'b1;
        drain("excl_release_drain", 40);

        // Asynchronous reset while a command waits in ISSUE
        req_ready = 1'b0;
        push(5, 1'b0, 1'b0, d);
        wait_valid("mid_issue_valid", 20);
        rst = 1'b0;
        #1;
        chk("arst_rd_fifo", 512'(rd_fifo), 512'(0));
        chk("arst_req_valid", 512'(req_valid), 512'(0));
        chk("arst_req_o", 512'(req_o), 512'(0));
        chk("arst_req_chan", 512'(req_chan), 512'(0));
        chk("arst_req_urgent", 512'(req_urgent), 512'(0));
        chk("arst_err_nov", 512'(err_nov), 512'(0));
        for (int i = 0; i < int'(NCHAN); i++) fq[i].delete();
        tick();
        rst = 1'b1;
        tick();
        req_ready = 1'b1;
        push(1, 1'b0, 1'b1, d);
        push(7, 1'b0, 1'b1, d);
        drain("arst_ptr_zero", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
